// File: rtl/dla_feeder_config_dispatcher.sv
// dla_feeder_config_dispatcher: steers packetised config words to one of NUM_CHANNELS feeder channels
module dla_feeder_config_dispatcher #(
  parameter int CONFIG_WIDTH = 32,
  parameter int NUM_CHANNELS = 5
) (
  input  logic                    clk,
  input  logic                    i_areset,
  input  logic [CONFIG_WIDTH-1:0] i_config_data,
  input  logic                    i_config_valid,
  output logic                    o_config_ready,
  output logic [CONFIG_WIDTH-1:0] o_channel_data,
  output logic [NUM_CHANNELS-1:0] o_channel_valid,
  input  logic [NUM_CHANNELS-1:0] i_channel_ready,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error
);
  localparam logic [1:0] IDLE = 2'd0, PAYLOAD = 2'd1, DROP = 2'd2;
  localparam logic [8:0] NCH = 9'(NUM_CHANNELS);
  logic [1:0] state, pend, total;
  logic [7:0] cnt, id, hdr_len, hdr_id;
  logic [NUM_CHANNELS-1:0] vld;
  logic [CONFIG_WIDTH-1:0] data_q;
  logic last, done_q, err_q, full, drain, accept, bad, idle_acc, drop_acc, load, cnt_last;
  assign hdr_len = i_config_data[7:0];
  assign hdr_id = i_config_data[15:8];
  assign bad = {1'b0, hdr_id} >= NCH;
  assign full = |vld;
  assign drain = |(vld & i_channel_ready);
  assign o_config_ready = ~i_areset & (state == PAYLOAD ? (~full | drain) : 1'b1);
  assign accept = i_config_valid & o_config_ready;
  assign idle_acc = accept & (state == IDLE);
  assign drop_acc = accept & (state == DROP);
  assign load = accept & (state == PAYLOAD);
  assign cnt_last = cnt == 8'd1;
  // Completion events can coincide (e.g. a LEN=0 header while the previous last word drains); pend keeps one pulse per packet.
  assign total = pend + 2'(drain & last) + 2'(idle_acc & (hdr_len == 8'd0)) + 2'(drop_acc & cnt_last);
  assign o_channel_data = data_q;
  assign o_channel_valid = vld;
  assign o_busy = (state != IDLE) | full;
  assign o_done = done_q;
  assign o_error = err_q;
  always_ff @(posedge clk or posedge i_areset)
    if (i_areset) begin
      state <= IDLE;
      cnt <= '0;
      id <= '0;
      vld <= '0;
      data_q <= '0;
      last <= 1'b0;
      pend <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      done_q <= total != 2'd0;
      pend <= total - 2'(total != 2'd0);
      if (idle_acc & bad) err_q <= 1'b1;
      if (load) begin
        data_q <= i_config_data;
        vld <= NUM_CHANNELS'(1) << id;
        last <= cnt_last;
      end else if (drain) vld <= '0;
      if (accept) begin
        state <= state == IDLE ? (hdr_len == 8'd0 ? IDLE : bad ? DROP : PAYLOAD) : (cnt_last ? IDLE : state);
        cnt <= state == IDLE ? hdr_len : cnt - 8'd1;
        if (state == IDLE) id <= hdr_id;
      end
    end
endmodule

// File: tb/tb_dla_feeder_config_dispatcher.sv
// tb_dla_feeder_config_dispatcher: directed vectors, corner sequences and a randomised scoreboard run
module tb_dla_feeder_config_dispatcher;
  logic clk = 1'b0, i_areset = 1'b1, i_config_valid = 1'b0, o_config_ready, o_busy, o_done, o_error;
  logic [31:0] i_config_data = '0, o_channel_data;
  logic [4:0] o_channel_valid, i_channel_ready = 5'h1f;
  int n_cmp = 0, n_err = 0;

  dla_feeder_config_dispatcher dut (
    .clk(clk), .i_areset(i_areset), .i_config_data(i_config_data), .i_config_valid(i_config_valid),
    .o_config_ready(o_config_ready), .o_channel_data(o_channel_data), .o_channel_valid(o_channel_valid),
    .i_channel_ready(i_channel_ready), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [31:0] d; logic [4:0] r;
    logic e_rdy; logic [4:0] e_vld; logic [31:0] e_dat; logic e_done, e_busy, e_err;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [31:0] d, logic [4:0] r, logic er, logic [4:0] ev,
                              logic [31:0] ed, logic edn, logic eb, logic ee);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.e_rdy = er; t.e_vld = ev; t.e_dat = ed; t.e_done = edn; t.e_busy = eb; t.e_err = ee;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] d, logic [4:0] r);
    i_config_valid = v; i_config_data = d; i_channel_ready = r;
    #4;
  endtask

  localparam logic [4:0] R = 5'h1f;
  localparam int NPK = 1000;

  initial begin
    int q_ch[$];
    logic [31:0] q_d[$], stream[$];
    int pk, rem, pid, cyc, n_done, len, id, cnt_ok;
    logic [31:0] r, hdr;
    logic rdy_exp, busy_exp;
    logic [4:0] vld_exp;
    // idle, transfer, drop, back-to-back packets (A/B/C, X drop words, D/E payloads)
    tbl.push_back(mk(1, 32'hDEAD0203, R, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'hAAAA0001, R, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 32'hAAAA0002, R, 1, 5'h04, 32'hAAAA0001, 0, 1, 0));
    tbl.push_back(mk(1, 32'hAAAA0003, R, 1, 5'h04, 32'hAAAA0002, 0, 1, 0));
    tbl.push_back(mk(0, 0, R, 1, 5'h04, 32'hAAAA0003, 0, 1, 0));
    tbl.push_back(mk(0, 0, R, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, R, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h00000704, R, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 32'h5A5A0000 + i, R, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, R, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, R, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 32'h00000001, R, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 32'hD0D0D0D0, R, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 32'h00000100, R, 1, 5'h01, 32'hD0D0D0D0, 0, 1, 1));
    tbl.push_back(mk(1, 32'h00000302, R, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 32'hE0000000, R, 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 32'hE1111111, R, 1, 5'h08, 32'hE0000000, 0, 1, 1));
    tbl.push_back(mk(0, 0, R, 1, 5'h08, 32'hE1111111, 0, 1, 1));
    tbl.push_back(mk(0, 0, R, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, R, 1, 0, 0, 0, 0, 1));

    #2;
    chk("reset_ready", 32'(o_config_ready), 0);
    chk("reset_valid", 32'(o_channel_valid), 0);
    repeat (3) tick;
    i_areset = 1'b0;
    #4;
    chk("post_reset_ready", 32'(o_config_ready), 1);
    chk("post_reset_data", o_channel_data, 0);
    chk("post_reset_busy", 32'(o_busy), 0);
    chk("post_reset_done", 32'(o_done), 0);
    chk("post_reset_error", 32'(o_error), 0);
    tick;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("vec%0d_ready", i), 32'(o_config_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_valid", i), 32'(o_channel_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld != 0) chk($sformatf("vec%0d_data", i), o_channel_data, tbl[i].e_dat);
      chk($sformatf("vec%0d_done", i), 32'(o_done), 32'(tbl[i].e_done));
      chk($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_error", i), 32'(o_error), 32'(tbl[i].e_err));
      tick;
    end

    // channel 4 stalls for five cycles with its first word held
    drive(1, 32'h00000402, 5'h0f); tick;
    drive(1, 32'h44440000, 5'h0f);
    chk("stall_first_ready", 32'(o_config_ready), 1);
    tick;
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h44440001, 5'h0f);
      chk("stall_hold_valid", 32'(o_channel_valid), 32'h10);
      chk("stall_hold_data", o_channel_data, 32'h44440000);
      chk("stall_ready_low", 32'(o_config_ready), 0);
      tick;
    end
    drive(1, 32'h44440001, R);
    chk("stall_release_ready", 32'(o_config_ready), 1);
    chk("stall_release_data", o_channel_data, 32'h44440000);
    tick;
    drive(0, 0, R);
    chk("stall_second_valid", 32'(o_channel_valid), 32'h10);
    chk("stall_second_data", o_channel_data, 32'h44440001);
    tick;
    drive(0, 0, R);
    chk("stall_done", 32'(o_done), 1);
    chk("stall_empty", 32'(o_channel_valid), 0);
    tick;

    // reset in the middle of a 10-word packet to channel 3
    drive(1, 32'h0000030A, 5'h17); tick;
    for (int i = 0; i < 3; i++) begin drive(1, 32'h33330000 + i, 5'h17); tick; end
    chk("mid_busy_before", 32'(o_busy), 1);
    i_areset = 1'b1;
    #1;
    chk("mid_reset_ready", 32'(o_config_ready), 0);
    chk("mid_reset_valid", 32'(o_channel_valid), 0);
    chk("mid_reset_data", o_channel_data, 0);
    chk("mid_reset_busy", 32'(o_busy), 0);
    chk("mid_reset_error", 32'(o_error), 0);
    i_config_valid = 1'b0;
    tick; tick;
    i_areset = 1'b0;
    drive(1, 32'h00000101, R);
    chk("mid_after_ready", 32'(o_config_ready), 1);
    tick;
    drive(1, 32'hF00DF00D, R); tick;
    drive(0, 0, R);
    chk("mid_after_valid", 32'(o_channel_valid), 32'h02);
    chk("mid_after_data", o_channel_data, 32'hF00DF00D);
    tick;
    drive(0, 0, R);
    chk("mid_after_done", 32'(o_done), 1);
    tick;

    // randomised traffic against a packet-level scoreboard
    pk = 0; rem = 0; pid = 0; cyc = 0; n_done = 0;
    while (!(pk == NPK && stream.size() == 0 && rem == 0 && q_ch.size() == 0) && cyc < 60000) begin
      if (stream.size() == 0 && pk < NPK) begin
        len = $urandom_range(0, 6);
        id = $urandom_range(0, 6);
        r = $urandom;
        hdr = {r[31:16], 8'(id), 8'(len)};
        stream.push_back(hdr);
        for (int i = 0; i < len; i++) stream.push_back($urandom);
        pk++;
      end
      drive(stream.size() != 0 && $urandom_range(0, 9) < 7, stream.size() != 0 ? stream[0] : $urandom,
            5'($urandom_range(0, 31)));
      vld_exp = q_ch.size() != 0 ? 5'(1) << q_ch[0] : 5'd0;
      busy_exp = rem > 0 || q_ch.size() != 0;
      rdy_exp = !(rem > 0 && pid < 5) || q_ch.size() == 0 || i_channel_ready[q_ch[0]];
      chk("rnd_valid", 32'(o_channel_valid), 32'(vld_exp));
      if (q_ch.size() != 0) chk("rnd_data", o_channel_data, q_d[0]);
      chk("rnd_busy", 32'(o_busy), 32'(busy_exp));
      chk("rnd_ready", 32'(o_config_ready), 32'(rdy_exp));
      if (o_done) n_done++;
      if (q_ch.size() != 0 && i_channel_ready[q_ch[0]]) begin
        void'(q_ch.pop_front());
        void'(q_d.pop_front());
      end
      if (i_config_valid && rdy_exp) begin
        if (rem == 0) begin
          rem = int'(stream[0][7:0]);
          pid = int'(stream[0][15:8]);
        end else begin
          rem--;
          if (pid < 5) begin q_ch.push_back(pid); q_d.push_back(stream[0]); end
        end
        void'(stream.pop_front());
      end
      tick;
      cyc++;
    end
    cnt_ok = cyc < 60000 ? 1 : 0;
    chk("rnd_timeout", 32'(cnt_ok), 1);
    i_config_valid = 1'b0;
    repeat (4) begin
      #4;
      if (o_done) n_done++;
      tick;
    end
    chk("rnd_done_count", 32'(n_done), NPK);
    chk("rnd_final_busy", 32'(o_busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
